sequenciador_giros: RTL and testbench

Initiator-side controller for the 360° servo rotation block: accepts a move request of 0–3 quarter turns from the cube-solving top level and runs the servo handshake once per quarter turn. Each turn pulses the servo's start input, waits for its done response, then waits a mechanical settle pause. It sits between the move planner and one servo instance. It reports completion or a timeout fault upward.

---
 rtl/sequenciador_giros_pkg.sv | 25 ++
 rtl/contador_m.sv | 34 +++
 rtl/sequenciador_giros_fd.sv | 78 +++++++
 rtl/sequenciador_giros_uc.sv | 105 ++++++++++
 rtl/sequenciador_giros.sv | 65 ++++++
 tb/tb_sequenciador_giros.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/sequenciador_giros_pkg.sv
// Shared definitions for the quarter-turn servo sequencer: state codes,
// default timing constants at 50 MHz and a small elaboration helper.
package sequenciador_giros_pkg;

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        PREPARACAO = 3'd1,
        DISPARA    = 3'd2,
        ESPERA     = 3'd3,
        PAUSA      = 3'd4,
        PROXIMO    = 3'd5,
        FIM        = 3'd6,
        ERRO       = 3'd7
    } estado_t;

    // 100 ms settle and 3 s servo timeout at 50 MHz
    localparam int PAUSA_CICLOS_PADRAO   = 5_000_000;
    localparam int TIMEOUT_CICLOS_PADRAO = 150_000_000;

    // Larger of two parameters; sizes the shared timer
    function automatic int maximo(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear (zera), enable (conta) and a
// terminal-count flag (fim) raised while the count sits at M-1.
module contador_m #(
    parameter int M = 16,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] q,
    output logic         fim
);

    // Count register: clear has priority over counting, wraps at M-1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= {N{1'b0}};
        end else if (zera) begin
            q <= {N{1'b0}};
        end else if (conta) begin
            if (q == N'(M - 1)) begin
                q <= {N{1'b0}};
            end else begin
                q <= q + N'(1'b1);
            end
        end else begin
            q <= q;
        end
    end

    assign fim = (q == N'(M - 1));

endmodule

// File: rtl/sequenciador_giros_fd.sv
// Datapath of the sequencer: captured turn request, turn counter and the
// single timer shared by the servo-done wait and the settle pause.
module sequenciador_giros_fd
    import sequenciador_giros_pkg::*;
#(
    parameter int PAUSA_CICLOS   = PAUSA_CICLOS_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       registra,
    input  logic       conta_giro,
    input  logic       zera_timer,
    input  logic       conta_timer,
    input  logic [1:0] quartos,
    output logic       quartos_zero,
    output logic       fim_timer,
    output logic       fim_pausa,
    output logic       fim_giros
);

    localparam int M_TIMER = maximo(PAUSA_CICLOS, TIMEOUT_CICLOS);
    localparam int W_TIMER = $clog2(M_TIMER);
    // The counter's own terminal flag serves whichever limit is the larger
    localparam bit TIMEOUT_MAIOR = (TIMEOUT_CICLOS >= PAUSA_CICLOS);

    logic [1:0]         quartos_r;
    logic [1:0]         giros_r;
    logic [1:0]         giros_prox_s;
    logic [W_TIMER-1:0] timer_s;
    logic               fim_modulo_s;

    // Capture the requested number of quarter turns when a request is accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quartos_r <= 2'd0;
        end else if (registra) begin
            quartos_r <= quartos;
        end else begin
            quartos_r <= quartos_r;
        end
    end

    // Completed-turn counter: cleared on accept, advanced once per turn
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            giros_r <= 2'd0;
        end else if (registra) begin
            giros_r <= 2'd0;
        end else if (conta_giro) begin
            giros_r <= giros_prox_s;
        end else begin
            giros_r <= giros_r;
        end
    end

    contador_m #(
        .M (M_TIMER),
        .N (W_TIMER)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timer),
        .conta (conta_timer),
        .q     (timer_s),
        .fim   (fim_modulo_s)
    );

    // Last turn is detected on the count the increment is about to produce
    assign giros_prox_s = giros_r + 2'd1;
    assign fim_giros    = (giros_prox_s == quartos_r);
    assign quartos_zero = (quartos_r == 2'd0);
    assign fim_timer    = TIMEOUT_MAIOR ? fim_modulo_s
                                        : (timer_s == W_TIMER'(TIMEOUT_CICLOS - 1));
    assign fim_pausa    = TIMEOUT_MAIOR ? (timer_s == W_TIMER'(PAUSA_CICLOS - 1))
                                        : fim_modulo_s;

endmodule

// File: rtl/sequenciador_giros_uc.sv
// Control unit: walks the start / wait-done / settle handshake once per
// quarter turn. Outputs are Moore, decoded from the state register.
module sequenciador_giros_uc
    import sequenciador_giros_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       servo_pronto,
    input  logic       quartos_zero,
    input  logic       fim_timer,
    input  logic       fim_pausa,
    input  logic       fim_giros,
    output logic       registra,
    output logic       conta_giro,
    output logic       zera_timer,
    output logic       conta_timer,
    output logic       servo_iniciar,
    output logic       pronto,
    output logic       erro,
    output logic [2:0] db_estado
);

    estado_t estado_r;
    estado_t proximo_s;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= INICIAL;
        end else begin
            estado_r <= proximo_s;
        end
    end

    // Next-state logic and datapath controls
    always_comb begin
        proximo_s   = estado_r;
        registra    = 1'b0;
        conta_giro  = 1'b0;
        zera_timer  = 1'b0;
        conta_timer = 1'b0;
        case (estado_r)
            INICIAL, ERRO: begin
                if (iniciar) begin
                    registra  = 1'b1;
                    proximo_s = PREPARACAO;
                end else begin
                    proximo_s = estado_r;
                end
            end
            PREPARACAO: begin
                if (quartos_zero) begin
                    proximo_s = FIM;
                end else begin
                    proximo_s = DISPARA;
                end
            end
            DISPARA: begin
                zera_timer = 1'b1;
                proximo_s  = ESPERA;
            end
            ESPERA: begin
                // Completion wins over a timeout on the same cycle
                if (servo_pronto) begin
                    zera_timer = 1'b1;
                    proximo_s  = PAUSA;
                end else if (fim_timer) begin
                    proximo_s = ERRO;
                end else begin
                    conta_timer = 1'b1;
                    proximo_s   = ESPERA;
                end
            end
            PAUSA: begin
                conta_timer = 1'b1;
                if (fim_pausa) begin
                    proximo_s = PROXIMO;
                end else begin
                    proximo_s = PAUSA;
                end
            end
            PROXIMO: begin
                conta_giro = 1'b1;
                if (fim_giros) begin
                    proximo_s = FIM;
                end else begin
                    proximo_s = DISPARA;
                end
            end
            FIM: begin
                proximo_s = INICIAL;
            end
            default: begin
                proximo_s = INICIAL;
            end
        endcase
    end

    assign servo_iniciar = (estado_r == DISPARA);
    assign pronto        = (estado_r == FIM);
    assign erro          = (estado_r == ERRO);
    assign db_estado     = estado_r;

endmodule

// File: rtl/sequenciador_giros.sv
// Quarter-turn servo sequencer: runs the servo start/done handshake plus a
// settle pause for each of 0-3 requested quarter turns, with a done timeout.
module sequenciador_giros
    import sequenciador_giros_pkg::*;
#(
    parameter int PAUSA_CICLOS   = PAUSA_CICLOS_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [1:0] quartos,
    output logic       pronto,
    output logic       erro,
    output logic       servo_iniciar,
    input  logic       servo_pronto,
    output logic [2:0] db_estado
);

    logic registra_s;
    logic conta_giro_s;
    logic zera_timer_s;
    logic conta_timer_s;
    logic quartos_zero_s;
    logic fim_timer_s;
    logic fim_pausa_s;
    logic fim_giros_s;

    sequenciador_giros_uc u_uc (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .servo_pronto  (servo_pronto),
        .quartos_zero  (quartos_zero_s),
        .fim_timer     (fim_timer_s),
        .fim_pausa     (fim_pausa_s),
        .fim_giros     (fim_giros_s),
        .registra      (registra_s),
        .conta_giro    (conta_giro_s),
        .zera_timer    (zera_timer_s),
        .conta_timer   (conta_timer_s),
        .servo_iniciar (servo_iniciar),
        .pronto        (pronto),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    sequenciador_giros_fd #(
        .PAUSA_CICLOS   (PAUSA_CICLOS),
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_fd (
        .clock        (clock),
        .reset        (reset),
        .registra     (registra_s),
        .conta_giro   (conta_giro_s),
        .zera_timer   (zera_timer_s),
        .conta_timer  (conta_timer_s),
        .quartos      (quartos),
        .quartos_zero (quartos_zero_s),
        .fim_timer    (fim_timer_s),
        .fim_pausa    (fim_pausa_s),
        .fim_giros    (fim_giros_s)
    );

endmodule

// File: tb/tb_sequenciador_giros.sv
// Bench for sequenciador_giros: directed requests, a servo model that answers
// a fixed delay after each start pulse, and a queue of expected output events
// (kind + cycle) filled from the request timing and drained as the DUT fires.
module tb_sequenciador_giros;

    localparam int PAUSA   = 4;
    localparam int TIMEOUT = 20;

    localparam int EV_SERVO  = 0;
    localparam int EV_PRONTO = 1;
    localparam int EV_ERRO   = 2;

    typedef struct {
        int tipo;
        int ciclo;
    } evento_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [1:0] quartos = 2'd0;
    logic       servo_pronto = 1'b0;
    logic       pronto;
    logic       erro;
    logic       servo_iniciar;
    logic [2:0] db_estado;

    evento_t fila[$];
    int      vetores = 0;
    int      falhas = 0;
    int      cyc = 0;
    int      pronto_em = -1;
    int      atraso = 6;
    int      giro_idx = 0;
    int      giro_mudo = 0;
    bit      erro_ant = 1'b0;

    sequenciador_giros #(
        .PAUSA_CICLOS   (PAUSA),
        .TIMEOUT_CICLOS (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .quartos       (quartos),
        .pronto        (pronto),
        .erro          (erro),
        .servo_iniciar (servo_iniciar),
        .servo_pronto  (servo_pronto),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        assert (obs === esp) else begin
            falhas++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, esp, cyc);
        end
    endtask

    task automatic empilha(input int tipo, input int ciclo_v);
        evento_t ev;
        ev.tipo  = tipo;
        ev.ciclo = ciclo_v;
        fila.push_back(ev);
    endtask

    // Expected events for a request whose iniciar is high in cycle t
    task automatic prever(input int t, input int q);
        int si;
        int s;
        if (q == 0) begin
            empilha(EV_PRONTO, t + 2);
            return;
        end
        si = t + 2;
        for (int k = 1; k <= q; k++) begin
            empilha(EV_SERVO, si);
            if (k == giro_mudo) begin
                empilha(EV_ERRO, si + 1 + TIMEOUT);
                return;
            end
            s = si + atraso;
            if (k == q) begin
                empilha(EV_PRONTO, s + PAUSA + 2);
            end else begin
                si = s + PAUSA + 2;
            end
        end
    endtask

    // One clock: check output events of this cycle, then drive the servo model
    task automatic ciclo();
        int      tipo_obs;
        evento_t ev;
        @(negedge clock);
        cyc++;
        if (servo_iniciar === 1'b1 || pronto === 1'b1 || (erro === 1'b1 && !erro_ant)) begin
            tipo_obs = (servo_iniciar === 1'b1) ? EV_SERVO :
                       ((pronto === 1'b1) ? EV_PRONTO : EV_ERRO);
            if (fila.size() == 0) begin
                confere("evento_extra", fila.size(), 1);
            end else begin
                ev = fila.pop_front();
                confere("evento_tipo", tipo_obs, ev.tipo);
                confere("evento_ciclo", cyc, ev.ciclo);
            end
        end
        if (servo_iniciar === 1'b1) begin
            giro_idx++;
            if (giro_idx != giro_mudo) begin
                pronto_em = cyc + atraso;
            end
        end
        servo_pronto = (cyc == pronto_em);
        erro_ant = (erro === 1'b1);
    endtask

    task automatic pedido(input logic [1:0] q);
        giro_idx = 0;
        iniciar  = 1'b1;
        quartos  = q;
        prever(cyc, int'(q));
        ciclo();
        iniciar = 1'b0;
    endtask

    task automatic aguarda(input logic [2:0] final_v, input int limite);
        int n;
        n = 0;
        while (!(fila.size() == 0 && db_estado === final_v) && n < limite) begin
            ciclo();
            n++;
        end
        confere("fila_pendente", fila.size(), 0);
        confere("estado_final", db_estado, final_v);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        confere("reset_pronto", pronto, 0);
        confere("reset_erro", erro, 0);
        confere("reset_servo_iniciar", servo_iniciar, 0);
        confere("reset_db_estado", db_estado, 0);
        reset = 1'b0;
        repeat (2) ciclo();

        // Two quarter turns
        pedido(2'd2);
        aguarda(3'd0, 100);
        confere("q2_erro", erro, 0);
        repeat (3) ciclo();

        // Zero turns: no servo start, pronto two cycles after iniciar
        pedido(2'd0);
        aguarda(3'd0, 20);

        // Servo silent on the second turn: timeout into ERRO
        giro_mudo = 2;
        pedido(2'd3);
        aguarda(3'd7, 100);
        repeat (3) begin
            ciclo();
            confere("erro_mantido", erro, 1);
            confere("erro_db_estado", db_estado, 7);
        end
        giro_mudo = 0;
        pedido(2'd1);
        confere("erro_cai", erro, 0);
        confere("erro_sai_prep", db_estado, 1);
        aguarda(3'd0, 100);

        // Done arriving on exactly the timeout cycle: completion wins
        atraso = TIMEOUT;
        pedido(2'd1);
        aguarda(3'd0, 100);
        confere("limite_sem_erro", erro, 0);
        atraso = 6;

        // iniciar/quartos toggled while busy are ignored
        pedido(2'd2);
        repeat (8) begin
            ciclo();
            iniciar = ~iniciar;
            quartos = 2'd3;
        end
        iniciar = 1'b0;
        aguarda(3'd0, 100);
        repeat (3) ciclo();

        // Reset asserted in PAUSA: outputs and state clear at once
        pedido(2'd2);
        begin
            int n;
            n = 0;
            while (db_estado !== 3'd4 && n < 50) begin
                ciclo();
                n++;
            end
        end
        confere("pausa_alcancada", db_estado, 4);
        reset = 1'b1;
        #1;
        confere("rst_db_estado", db_estado, 0);
        confere("rst_servo_iniciar", servo_iniciar, 0);
        confere("rst_pronto", pronto, 0);
        confere("rst_erro", erro, 0);
        fila.delete();
        pronto_em = -1;
        servo_pronto = 1'b0;
        ciclo();
        reset = 1'b0;
        ciclo();
        pedido(2'd2);
        aguarda(3'd0, 100);
        repeat (5) ciclo();
        confere("fim_fila_vazia", fila.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
        $finish;
    end

endmodule
